seven_seg_controller: RTL and testbench

- Time-multiplexed driver for a 3-digit, common-anode 7-segment display showing a 12-bit value as three hex digits.
- Sits downstream of the page-select logic, which picks a 12-bit window of the processor's data address, and the button debouncers.
- The 2-bit page input drives the decimal point so the user can see which window is shown.
- Runs on the slow scan clock (~kHz) derived from the raw board clock.

---
 rtl/seven_seg_controller.sv | 74 +++++++
 tb/tb_seven_seg_controller.sv | 113 +++++++++++
 2 files changed

// File: rtl/seven_seg_controller.sv
// seven_seg_controller: scans value[11:0] as three hex digits (CLK, reset, value, page in; a..g, SE0..SE2, dot out; registered, polarity by ACTIVE_LOW)
module seven_seg_controller #(
  parameter int unsigned SCAN_DIV   = 1,
  parameter bit          ACTIVE_LOW = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [11:0] value,
  input  logic [1:0]  page,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        SE0,
  output logic        SE1,
  output logic        SE2,
  output logic        dot
);
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  seg_q, seg_d;
  logic [2:0]  en_q, en_d;
  logic        dot_q, dot_d;
  logic [3:0]  nib;
  logic        wrap;
  always_comb begin
    nib   = idx_q == 2'd0 ? value[11:8] : idx_q == 2'd1 ? value[7:4] : value[3:0];
    wrap  = cnt_q == 16'(SCAN_DIV - 1);
    cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
    idx_d = !wrap ? idx_q : idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1;
    en_d  = 3'b100 >> idx_q;
    dot_d = page == idx_q;
    seg_d = 7'b0000000;
    case (nib)
      4'h0: seg_d = 7'b1111110;
      4'h1: seg_d = 7'b0110000;
      4'h2: seg_d = 7'b1101101;
      4'h3: seg_d = 7'b1111001;
      4'h4: seg_d = 7'b0110011;
      4'h5: seg_d = 7'b1011011;
      4'h6: seg_d = 7'b1011111;
      4'h7: seg_d = 7'b1110000;
      4'h8: seg_d = 7'b1111111;
      4'h9: seg_d = 7'b1111011;
      4'hA: seg_d = 7'b1110111;
      4'hB: seg_d = 7'b0011111;
      4'hC: seg_d = 7'b1001110;
      4'hD: seg_d = 7'b0111101;
      4'hE: seg_d = 7'b1001111;
      default: seg_d = 7'b1000111;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      idx_q <= 2'd0;
      cnt_q <= 16'd0;
      seg_q <= 7'b0000000;
      en_q  <= 3'b000;
      dot_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      seg_q <= seg_d;
      en_q  <= en_d;
      dot_q <= dot_d;
    end
  end
  assign {a, b, c, d, e, f, g} = seg_q ^ {7{ACTIVE_LOW}};
  assign {SE0, SE1, SE2}       = en_q ^ {3{ACTIVE_LOW}};
  assign dot                   = dot_q ^ ACTIVE_LOW;
endmodule

// File: tb/tb_seven_seg_controller.sv
// tb_seven_seg_controller: directed and random checks of two scan-rate variants against an edge-count model
module tb_seven_seg_controller;
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] value = 12'h000;
  logic [1:0]  page = 2'b00;
  logic [6:0]  s1, s4;
  logic [2:0]  e1, e4;
  logic        dt1, dt4;
  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  logic [6:0]  tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  always #5 CLK = ~CLK;

  seven_seg_controller #(.SCAN_DIV(1), .ACTIVE_LOW(1)) dut1 (
    .CLK(CLK), .reset(reset), .value(value), .page(page),
    .a(s1[6]), .b(s1[5]), .c(s1[4]), .d(s1[3]), .e(s1[2]), .f(s1[1]), .g(s1[0]),
    .SE0(e1[2]), .SE1(e1[1]), .SE2(e1[0]), .dot(dt1)
  );
  seven_seg_controller #(.SCAN_DIV(4), .ACTIVE_LOW(1)) dut4 (
    .CLK(CLK), .reset(reset), .value(value), .page(page),
    .a(s4[6]), .b(s4[5]), .c(s4[4]), .d(s4[3]), .e(s4[2]), .f(s4[1]), .g(s4[0]),
    .SE0(e4[2]), .SE1(e4[1]), .SE2(e4[0]), .dot(dt4)
  );

  // Pins after an edge: digit shown is (edges since release / div) mod 3, pins active-low.
  function automatic logic [10:0] model(input logic r, input int n, input int div,
                                        input logic [11:0] v, input logic [1:0] p);
    int dg;
    logic [3:0] nb;
    if (r) return 11'h7FF;
    dg = (n / div) % 3;
    nb = 4'((v >> (4 * (2 - dg))) & 12'hF);
    return {~tbl[nb], ~(3'b100 >> dg), ~(int'(p) == dg)};
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input string tag);
    reset = r;
    @(posedge CLK);
    #1;
    chk({tag, "/div1"}, {s1, e1, dt1}, model(r, k, 1, value, page));
    chk({tag, "/div4"}, {s4, e4, dt4}, model(r, k, 4, value, page));
    k = r ? 0 : k + 1;
  endtask

  initial begin
    value = 12'hABC;
    repeat (3) tick(1'b1, "reset");
    chk("reset_lit", {s1, e1, dt1}, 11'h7FF);

    value = 12'h1F0;
    page  = 2'b00;
    tick(1'b0, "scan0");
    chk("scan0_lit", {s1, e1, dt1}, {7'b1001111, 3'b011, 1'b0});
    tick(1'b0, "scan1");
    chk("scan1_lit", {s1, e1, dt1}, {7'b0111000, 3'b101, 1'b1});
    tick(1'b0, "scan2");
    chk("scan2_lit", {s1, e1, dt1}, {7'b0000001, 3'b110, 1'b1});
    tick(1'b0, "scan3");
    chk("scan3_lit", {s1, e1}, {7'b1001111, 3'b011});

    value = 12'h888;
    page  = 2'b01;
    repeat (6) tick(1'b0, "dot01");
    page = 2'b11;
    repeat (6) tick(1'b0, "dot11");
    chk("dot11_lit", {10'h000, dt1}, 11'd1);
    page = 2'b10;
    repeat (3) tick(1'b0, "dot10");

    for (int n = 0; n < 16; n++) begin
      value = {4'(n), 4'(n), 4'(n)};
      repeat (3) tick(1'b0, "sweep");
    end

    page  = 2'b00;
    value = 12'h5A3;
    repeat (24) tick(1'b0, "prescale");

    while (e1 !== 3'b110) tick(1'b0, "to_se2");
    tick(1'b1, "midreset");
    tick(1'b0, "restart");
    chk("restart_lit", {4'h0, e1, e4, 1'b0}, {4'h0, 3'b011, 3'b011, 1'b0});

    for (int i = 0; i < 300; i++) begin
      value = 12'($urandom);
      page  = 2'($urandom);
      tick($urandom_range(0, 24) == 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
